xor_stream_cipher_ch: RTL
=========================

Name: xor_stream_cipher_ch

Overview:
- Parametrised, streaming successor to the fixed 3-channel, 16384-entry memory decryptor.
- Combines a per-pixel data stream with the chaotic-LFSR keystream over CH channels of W bits, in encrypt or decrypt direction.
- Supports plain XOR and a chained (ciphertext-feedback) diffusion mode.
- Sits between the pixel source (frame buffer / UART loader) and the sink, on both transmitter and receiver sides. Frame length is fixed by DEPTH; all image storage is outside this block.

Parameters:
- CH, 3, number of colour channels per pixel
- W, 8, bits per channel
- DEPTH, 16384, pixels per frame
- IV, 0, initial chaining value, W bits, applied to every channel at start
- CW, $clog2(DEPTH+1), width of the pixel counter

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a frame when in IDLE or DONE
- dir  in  1  0 = encrypt, 1 = decrypt; sampled on accepted start
- chain_en  in  1  0 = plain XOR, 1 = chained mode; sampled on accepted start
- in_valid  in  1  pixel data valid
- in_data  in  CH*W  pixel; channel i is bits [i*W +: W]
- in_ready  out  1  pixel accepted this cycle
- key_valid  in  1  keystream word valid
- key_data  in  CH*W  keystream word, same channel packing
- key_ready  out  1  keystream word consumed this cycle
- out_valid  out  1  result valid
- out_data  out  CH*W  result pixel
- out_ready  in  1  sink accepts result
- busy  out  1  high in RUN and FLUSH
- done  out  1  sticky frame-complete flag
- count  out  CW  pixels accepted in the current frame

Behaviour:
- Reset values: all outputs 0, state IDLE. The chain register holds IV in every channel; mode latches are 0.
- States:
  - IDLE: waits for start; start -> RUN. On start: clear count, load chain register with IV, latch dir and chain_en, clear done.
  - RUN: accepts pixels. count==DEPTH after an accept -> FLUSH.
  - FLUSH: no accepts; waits until out_valid is 0, or out_valid&&out_ready this cycle -> DONE.
  - DONE: done=1, busy=0. start -> RUN with the same initialisation as from IDLE.
- start in RUN or FLUSH is ignored; dir and chain_en changes mid-frame have no effect.
- Accept condition: acc = RUN && in_valid && key_valid && (!out_valid || out_ready).
  - in_ready = key_ready = acc. Pixel and key are always consumed together; one is never consumed without the other.
  - in_ready may depend combinationally on key_valid and in_valid. Neither valid may depend on ready.
- Per channel i, on acc (p = in word, k = key word, q = chain register):
  - plain mode: r = p ^ k
  - chained encrypt: r = p ^ k ^ q; q <= r
  - chained decrypt: r = p ^ k ^ q; q <= p (the incoming ciphertext)
  - plain mode leaves q unchanged.
- Latency: registered output. r appears on out_data with out_valid=1 in the cycle after acc.
- Output register:
  - holds value and out_valid while out_valid && !out_ready;
  - cleared when out_ready and no new acc;
  - overwritten back-to-back when out_ready && acc, so one pixel per cycle is sustained.
- count increments by 1 per acc and saturates at DEPTH. The DEPTH-th accept moves the FSM to FLUSH in the same edge; no further accepts happen.
- done asserts on entry to DONE and stays high until the next accepted start.
- Reset mid-frame: immediate return to reset values. The in-flight output is discarded.
- Encrypt then decrypt with identical keystream, IV and chain_en must reproduce the plaintext bit-exactly.

Test Plan:
- Plain XOR, CH=3, W=8, DEPTH=4: pixels 0x112233, 0x445566, 0x778899, 0xAABBCC; keys all 0xFFFFFF; out_ready=1 -> outputs 0xEEDDCC, 0xBBAA99, 0x887766, 0x554433 on consecutive cycles. done=1 two cycles after the last accept; count=4.
- Chained encrypt, IV=0, DEPTH=3: p=0x010101 x3, k=0x000000 -> out 0x010101, 0x000000, 0x010101. Chained decrypt of that stream with the same key -> 0x010101 x3.
- Backpressure: out_ready=0 for 5 cycles after the first result -> out_data stable, in_ready=key_ready=0. Then out_ready=1 -> remaining pixels flow with no loss or duplication.
- Keystream stall: key_valid low on alternate cycles, in_valid constant -> in_ready follows key_valid, no pixel consumed without a key, output sequence correct.
- Reset mid-frame after 2 of 4 accepts -> all outputs 0 next edge, state IDLE. A new start runs a full frame with the chain restarted from IV.
- start pulsed during RUN -> ignored, count unchanged. start in DONE -> done clears, count=0, second frame processes correctly.

Source files
------------

// File: rtl/xor_stream_cipher_ch.sv
// Streaming pixel/keystream XOR cipher over CH channels, plain or chained (ciphertext feedback).
// One-cycle registered output; pixel and key are consumed together only when the output slot is free.
module xor_stream_cipher_ch #(
    parameter int             CH    = 3,
    parameter int             W     = 8,
    parameter int             DEPTH = 16384,
    parameter logic [W-1:0]   IV    = '0,
    parameter int             CW    = $clog2(DEPTH+1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              dir,
    input  logic              chain_en,
    input  logic              in_valid,
    input  logic [CH*W-1:0]   in_data,
    output logic              in_ready,
    input  logic              key_valid,
    input  logic [CH*W-1:0]   key_data,
    output logic              key_ready,
    output logic              out_valid,
    output logic [CH*W-1:0]   out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [CW-1:0]     count
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam logic [CW-1:0]   LAST_CNT = CW'(DEPTH - 1);
    localparam logic [CW-1:0]   MAX_CNT  = CW'(DEPTH);
    localparam logic [CH*W-1:0] IV_ALL   = {CH{IV}};

    state_t          state, state_nxt;
    logic            dir_q, chain_q;
    logic [CH*W-1:0] chain_reg;
    logic [CH*W-1:0] result;
    logic            acc;
    logic            start_acc;

    assign start_acc = start && (state == IDLE || state == DONE);
    assign acc       = (state == RUN) && in_valid && key_valid && (!out_valid || out_ready);
    assign in_ready  = acc;
    assign key_ready = acc;
    assign busy      = (state == RUN) || (state == FLUSH);
    assign done      = (state == DONE);

    // XOR is bitwise, so the whole packed word handles every channel independently.
    assign result = in_data ^ key_data ^ (chain_q ? chain_reg : '0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = RUN;
            RUN:        if (acc && count == LAST_CNT) state_nxt = FLUSH;
            FLUSH:      if (!out_valid || out_ready) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            chain_reg <= IV_ALL;
            dir_q     <= 1'b0;
            chain_q   <= 1'b0;
        end else if (start_acc) begin
            count     <= '0;
            chain_reg <= IV_ALL;
            dir_q     <= dir;
            chain_q   <= chain_en;
        end else if (acc) begin
            if (count != MAX_CNT) count <= count + 1'b1;
            // Decrypt feeds back the received ciphertext so both ends track the same chain.
            if (chain_q) chain_reg <= dir_q ? in_data : result;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (acc) begin
            out_valid <= 1'b1;
            out_data  <= result;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end
    end

endmodule
